block_gearbox: RTL

Repacks the variable-occupancy block stream produced by the 8-lane block-merge tree (up to 8 valid blocks per beat, count on `in_num`) into dense full-width beats of exactly `NUM_LANES` blocks. A partial word is emitted only at end of stream. It sits directly downstream of the merge tree and feeds the fixed-width writer, which then needs no per-beat occupancy handling except on the final beat.

---
 rtl/block_gearbox_if.sv | 32 +++
 rtl/block_gearbox.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/block_gearbox_if.sv
// block_gearbox_if: upstream input beat signals and downstream output beat
// signals of the block gearbox, bundled so both sides share one declaration.
// Handshake: a beat transfers on a rising clk edge where its valid and the
// matching ready (in_ready for input, ready_4_output for output) are both 1.
// A valid beat holds its payload stable until it transfers.
interface block_gearbox_if #(
    parameter int BLOCK_SIZE = 128,
    parameter int NUM_LANES  = 8
);
    logic                            in_ready;
    logic [NUM_LANES*BLOCK_SIZE-1:0] in_data;
    logic                            in_valid;
    logic [31:0]                     in_num;
    logic                            in_last;
    logic                            ready_4_output;
    logic [NUM_LANES*BLOCK_SIZE-1:0] out_data;
    logic                            out_valid;
    logic [31:0]                     out_num;
    logic                            out_last;

    // Stream source / sink side (merge tree upstream, writer downstream).
    modport master (
        output in_data, in_valid, in_num, in_last, ready_4_output,
        input  in_ready, out_data, out_valid, out_num, out_last
    );

    // Gearbox side.
    modport slave (
        input  in_data, in_valid, in_num, in_last, ready_4_output,
        output in_ready, out_data, out_valid, out_num, out_last
    );
endinterface

// File: rtl/block_gearbox.sv
// block_gearbox: repacks variable-occupancy block beats into dense beats of
// NUM_LANES blocks; only the final beat of a stream may be partial.
// Optional build macro BLOCK_GEARBOX_ZERO_PAD_EN: when defined, output slots
// at or above out_num and buffer slots freed by a shift read as zero; when
// undefined they hold stale data.
module block_gearbox #(
    parameter int  BLOCK_SIZE = 128,
    parameter int  NUM_LANES  = 8,
    localparam int IDX_W      = $clog2(2*NUM_LANES),
    localparam int CNT_W      = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    block_gearbox_if.slave   bus,
    output logic             dbg_state,   // 0 = FILL, 1 = FLUSH
    output logic [CNT_W-1:0] dbg_cnt
);

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LANES   = CNT_W'(NUM_LANES);
    localparam logic [CNT_W-1:0] BUF_LEN = CNT_W'(2*NUM_LANES);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BLOCK_SIZE-1:0] buf_q [2*NUM_LANES];
    logic [BLOCK_SIZE-1:0] buf_d [2*NUM_LANES];

    logic                  in_ready_c;
    logic                  out_valid_c;
    logic                  out_last_c;
    logic [CNT_W-1:0]      out_num_c;
    logic                  emit;
    logic                  accept;
    logic [CNT_W-1:0]      in_cnt;
    logic [CNT_W-1:0]      emitted;
    logic [CNT_W-1:0]      cnt_after_emit;

    // Handshake decode, occupancy bookkeeping and FILL/FLUSH transitions.
    always_comb begin
        in_cnt      = (bus.in_num > 32'(NUM_LANES)) ? LANES : CNT_W'(bus.in_num);
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_num_c   = LANES;
        out_last_c  = 1'b0;
        state_d     = state_q;
        unique case (state_q)
            FILL: begin
                out_valid_c = (cnt_q >= LANES);
                in_ready_c  = (cnt_q < LANES) || (out_valid_c && bus.ready_4_output);
            end
            FLUSH: begin
                out_valid_c = 1'b1;
                out_num_c   = (cnt_q < LANES) ? cnt_q : LANES;
                out_last_c  = (cnt_q <= LANES);
            end
            default: ;
        endcase
        emit           = out_valid_c && bus.ready_4_output;
        accept         = bus.in_valid && in_ready_c;
        emitted        = emit ? out_num_c : '0;
        cnt_after_emit = cnt_q - emitted;
        // Worst case is (NUM_LANES-1) held + NUM_LANES arriving, which fits.
        cnt_d          = cnt_after_emit + (accept ? in_cnt : '0);
        if (state_q == FILL && accept && bus.in_last) begin
            state_d = FLUSH;
        end
        if (state_q == FLUSH && emit && out_last_c) begin
            state_d = FILL;
            cnt_d   = '0;
        end
    end

    // Buffer next value: shift out the emitted blocks, then append the
    // accepted ones directly behind whatever remains.
    always_comb begin
        logic [CNT_W-1:0] src;
        logic [CNT_W-1:0] dst;
        src = '0;
        dst = '0;
        for (int i = 0; i < 2*NUM_LANES; i++) begin
`ifdef BLOCK_GEARBOX_ZERO_PAD_EN
            buf_d[i] = '0;
`else
            buf_d[i] = buf_q[i];
`endif
            src = CNT_W'(i) + emitted;
            if (src < BUF_LEN) begin
                buf_d[i] = buf_q[src[IDX_W-1:0]];
            end
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            dst = cnt_after_emit + CNT_W'(k);
            if (accept && (CNT_W'(k) < in_cnt) && (dst < BUF_LEN)) begin
                buf_d[dst[IDX_W-1:0]] = bus.in_data[k*BLOCK_SIZE +: BLOCK_SIZE];
            end
        end
    end

    // Output word is the oldest NUM_LANES buffer slots.
    always_comb begin
        logic [BLOCK_SIZE-1:0] blk;
        blk          = '0;
        bus.out_data = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            blk = buf_q[k];
`ifdef BLOCK_GEARBOX_ZERO_PAD_EN
            if (CNT_W'(k) >= out_num_c) begin
                blk = '0;
            end
`endif
            bus.out_data[k*BLOCK_SIZE +: BLOCK_SIZE] = blk;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_num   = 32'(out_num_c);
    assign bus.out_last  = out_last_c;
    assign dbg_state     = state_q;
    assign dbg_cnt       = cnt_q;

    // State, occupancy and buffer registers; reset discards any stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            for (int i = 0; i < 2*NUM_LANES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 2*NUM_LANES; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule
